// File: rtl/cam_capture_writer_if.sv
// Bundle between the camera pins, the capture writer and the 1-bit frame-buffer write port.
// Optional CAPTURE_ARM_EN adds capture_req/armed for single-shot capture.
interface cam_capture_writer_if;
  logic        cam_pclk;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;

  // Write is a one-cycle strobe with no back-pressure: Addr/WData are valid
  // only while Write=1, and the frame buffer must accept every strobe.
  logic        Write;
  logic [18:0] Addr;
  logic        WData;
  logic        frame_done;
  logic        busy;
  logic [1:0]  dbg_state;
`ifdef CAPTURE_ARM_EN
  logic        capture_req;
  logic        armed;
`endif

`ifdef CAPTURE_ARM_EN
  modport slave (
    input  cam_pclk, cam_vsync, cam_href, cam_data, capture_req,
    output Write, Addr, WData, frame_done, busy, dbg_state, armed
  );
  modport master (
    output cam_pclk, cam_vsync, cam_href, cam_data, capture_req,
    input  Write, Addr, WData, frame_done, busy, dbg_state, armed
  );
`else
  modport slave (
    input  cam_pclk, cam_vsync, cam_href, cam_data,
    output Write, Addr, WData, frame_done, busy, dbg_state
  );
  modport master (
    output cam_pclk, cam_vsync, cam_href, cam_data,
    input  Write, Addr, WData, frame_done, busy, dbg_state
  );
`endif
endinterface

// File: rtl/cam_capture_writer.sv
// Camera YUV422 capture -> thresholded 1-bit raster writes into the frame buffer.
// Define CAPTURE_ARM_EN for single-shot capture armed by capture_req.
module cam_capture_writer #(
  parameter int H_ACT    = 640,
  parameter int V_ACT    = 480,
  parameter int Y_THRESH = 128
) (
  input  logic                dclk,
  input  logic                clr_n,
  cam_capture_writer_if.slave bus
);

  localparam int CW = $clog2(H_ACT + 1);
  localparam int RW = $clog2(V_ACT + 1);
  localparam logic [CW-1:0] H_MAX  = CW'(H_ACT);
  localparam logic [RW-1:0] V_MAX  = RW'(V_ACT);
  localparam logic [RW-1:0] V_LAST = RW'(V_ACT - 1);
  localparam logic [18:0]   H_STEP = 19'(H_ACT);
  localparam logic [8:0]    Y_TH9  = 9'(Y_THRESH);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_VBLANK    = 2'd1,
    S_WAIT_LINE = 2'd2,
    S_LINE      = 2'd3
  } state_t;

  // Single-shot capture parks in IDLE so a new request can re-arm it.
`ifdef CAPTURE_ARM_EN
  localparam state_t S_REST = S_IDLE;
`else
  localparam state_t S_REST = S_VBLANK;
`endif

  logic [2:0]    r_pclk_sync;
  logic [1:0]    r_vs_sync;
  logic [1:0]    r_href_sync;
  logic [7:0]    r_data_s1;
  logic [7:0]    r_data_s2;

  state_t        r_state;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic          r_phase;
  logic [18:0]   r_base;
  logic          r_vs_prev;
  logic          r_write;
  logic [18:0]   r_addr;
  logic          r_wdata;
  logic          r_frame_done;
  logic          r_busy;

  logic          w_edge;
  logic          w_vs;
  logic          w_href;
  logic          w_ybit;
  logic          w_go;

  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      r_pclk_sync <= '0;
      r_vs_sync   <= '0;
      r_href_sync <= '0;
      r_data_s1   <= '0;
      r_data_s2   <= '0;
    end else begin
      r_pclk_sync <= {r_pclk_sync[1:0], bus.cam_pclk};
      r_vs_sync   <= {r_vs_sync[0], bus.cam_vsync};
      r_href_sync <= {r_href_sync[0], bus.cam_href};
      r_data_s1   <= bus.cam_data;
      r_data_s2   <= r_data_s1;
    end
  end

  assign w_edge = r_pclk_sync[1] & ~r_pclk_sync[2];
  assign w_vs   = r_vs_sync[1];
  assign w_href = r_href_sync[1];
  assign w_ybit = ({1'b0, r_data_s2} >= Y_TH9);

`ifdef CAPTURE_ARM_EN
  logic r_armed;
  logic w_end;

  assign w_end = w_edge && (r_state == S_WAIT_LINE || r_state == S_LINE) &&
                 (w_vs || (r_state == S_LINE && !w_href && r_col != '0 && r_row == V_LAST));

  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      r_armed <= 1'b0;
    end else if (w_end) begin
      r_armed <= 1'b0;
    end else if (bus.capture_req && r_state == S_IDLE) begin
      r_armed <= 1'b1;
    end
  end

  assign w_go      = r_armed;
  assign bus.armed = r_armed;
`else
  assign w_go = 1'b1;
`endif

  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      r_state      <= S_IDLE;
      r_row        <= '0;
      r_col        <= '0;
      r_phase      <= 1'b0;
      r_base       <= '0;
      r_vs_prev    <= 1'b0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_write      <= 1'b0;
      r_frame_done <= 1'b0;
      if (w_edge) begin
        r_vs_prev <= w_vs;
        case (r_state)
          S_IDLE: begin
            if (w_vs && w_go) r_state <= S_VBLANK;
          end
          S_VBLANK: begin
            if (r_vs_prev && !w_vs) begin
              r_state <= S_WAIT_LINE;
              r_busy  <= 1'b1;
              r_row   <= '0;
              r_base  <= '0;
            end
          end
          S_WAIT_LINE: begin
            if (w_vs) begin
              r_state <= S_REST;
              r_busy  <= 1'b0;
            end else if (w_href) begin
              // The line's first byte is its first Y sample at column 0.
              r_state <= S_LINE;
              r_phase <= 1'b1;
              r_col   <= (H_MAX != '0) ? CW'(1) : '0;
              if (r_row < V_MAX && H_MAX != '0) begin
                r_write <= 1'b1;
                r_addr  <= r_base;
                r_wdata <= w_ybit;
              end
            end
          end
          S_LINE: begin
            if (w_vs) begin
              r_state <= S_REST;
              r_busy  <= 1'b0;
            end else if (!w_href) begin
              r_col   <= '0;
              r_phase <= 1'b0;
              if (r_col != '0 && r_row == V_LAST) begin
                r_row        <= V_MAX;
                r_frame_done <= 1'b1;
                r_state      <= S_REST;
                r_busy       <= 1'b0;
              end else begin
                r_state <= S_WAIT_LINE;
                if (r_col != '0 && r_row < V_MAX) begin
                  r_row  <= r_row + RW'(1);
                  r_base <= r_base + H_STEP;
                end
              end
            end else if (!r_phase) begin
              r_phase <= 1'b1;
              if (r_col < H_MAX) begin
                r_col <= r_col + CW'(1);
                if (r_row < V_MAX) begin
                  r_write <= 1'b1;
                  r_addr  <= r_base + 19'(r_col);
                  r_wdata <= w_ybit;
                end
              end
            end else begin
              r_phase <= 1'b0;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.Write      = r_write;
  assign bus.Addr       = r_addr;
  assign bus.WData      = r_wdata;
  assign bus.frame_done = r_frame_done;
  assign bus.busy       = r_busy;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_cam_capture_writer.sv
// Bench for cam_capture_writer on a reduced 16x8 raster; frames are described
// by a table plus random frames, and every write is checked against a model queue.
module tb_cam_capture_writer;
  localparam int H = 16;
  localparam int V = 8;
  localparam int T = 128;

  logic dclk  = 1'b0;
  logic clr_n = 1'b0;

  cam_capture_writer_if bus();

  cam_capture_writer #(.H_ACT(H), .V_ACT(V), .Y_THRESH(T)) dut (
    .dclk  (dclk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  always #5 dclk = ~dclk;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_wr   = 0;
  int n_done = 0;
  int m_done = 0;
  logic prev_wr = 1'b0;
  logic [19:0] exp_q[$];

  typedef struct {
    int lines;
    int px;
    int mode;
    int ab_row;
    int ab_col;
    int exp_wr;
    int exp_done;
  } vec_t;

  vec_t tab[6];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every strobe must match the head of the model queue.
  always @(negedge dclk) begin
    logic [19:0] e;
    if (clr_n) begin
      if (bus.frame_done) n_done++;
      if (bus.Write) begin
        n_wr++;
        chk("write_gap", int'(prev_wr), 0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got Addr %0d, expected no write", bus.Addr);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", int'(bus.Addr), int'(e[19:1]));
          chk("wr_data", int'(bus.WData), int'(e[0]));
        end
      end
      prev_wr = bus.Write;
    end else begin
      prev_wr = 1'b0;
    end
  end

  task automatic cam_byte(input logic vs, input logic hr, input logic [7:0] d);
    bus.cam_pclk  = 1'b0;
    bus.cam_vsync = vs;
    bus.cam_href  = hr;
    bus.cam_data  = d;
    repeat (2) @(negedge dclk);
    bus.cam_pclk = 1'b1;
    repeat (2) @(negedge dclk);
  endtask

  // px < 0 picks a random length per line; mode 0 = Y 200, 1 = 127/128, 2 = random.
  task automatic drive_frame(input int lines, input int px_fixed, input int mode,
                             input int ab_row, input int ab_col, input bit arm);
    int  r;
    bit  captured;
    r        = 0;
    captured = 1'b1;
`ifdef CAPTURE_ARM_EN
    captured = arm;
`endif
    cam_byte(1'b1, 1'b0, 8'h00);
`ifdef CAPTURE_ARM_EN
    if (arm) begin
      bus.capture_req = 1'b1;
      @(negedge dclk);
      bus.capture_req = 1'b0;
    end
`endif
    cam_byte(1'b1, 1'b0, 8'h00);
    cam_byte(1'b1, 1'b0, 8'h00);
    cam_byte(1'b0, 1'b0, 8'h00);
    cam_byte(1'b0, 1'b0, 8'h00);
    for (int l = 0; l < lines; l++) begin
      int px;
      px = (px_fixed < 0) ? int'($urandom_range(0, H + 4)) : px_fixed;
      for (int c = 0; c < px; c++) begin
        logic [7:0] y;
        logic       b;
        if (l == ab_row && c == ab_col) begin
          cam_byte(1'b1, 1'b1, 8'd200);
          cam_byte(1'b1, 1'b0, 8'h00);
          cam_byte(1'b1, 1'b0, 8'h00);
          return;
        end
        case (mode)
          0:       y = 8'd200;
          1:       y = (c % 2 == 1) ? 8'd128 : 8'd127;
          default: y = 8'($urandom_range(0, 255));
        endcase
        b = (int'(y) >= T);
        if (captured && r < V && c < H) exp_q.push_back({19'(r * H + c), b});
        cam_byte(1'b0, 1'b1, y);
        cam_byte(1'b0, 1'b1, 8'hFF);
      end
      cam_byte(1'b0, 1'b0, 8'h00);
      cam_byte(1'b0, 1'b0, 8'h00);
      if (px > 0) begin
        r++;
        if (captured && r == V) m_done++;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0;
    int dn0;

    tab[0] = '{lines: V,      px: H,      mode: 0, ab_row: -1, ab_col: -1, exp_wr: H * V, exp_done: 1};
    tab[1] = '{lines: V,      px: H,      mode: 1, ab_row: -1, ab_col: -1, exp_wr: H * V, exp_done: 1};
    tab[2] = '{lines: V,      px: H + 4,  mode: 2, ab_row: -1, ab_col: -1, exp_wr: H * V, exp_done: 1};
    tab[3] = '{lines: V,      px: H,      mode: 0, ab_row: 3,  ab_col: 5,  exp_wr: 3 * H + 5, exp_done: 0};
    tab[4] = '{lines: V + 2,  px: H,      mode: 2, ab_row: -1, ab_col: -1, exp_wr: H * V, exp_done: 1};
    tab[5] = '{lines: V,      px: 10,     mode: 1, ab_row: -1, ab_col: -1, exp_wr: 10 * V, exp_done: 1};

    bus.cam_pclk  = 1'b0;
    bus.cam_vsync = 1'b0;
    bus.cam_href  = 1'b0;
    bus.cam_data  = 8'h00;
`ifdef CAPTURE_ARM_EN
    bus.capture_req = 1'b0;
`endif

    repeat (3) @(negedge dclk);
    chk("rst_write",      int'(bus.Write),      0);
    chk("rst_addr",       int'(bus.Addr),       0);
    chk("rst_wdata",      int'(bus.WData),      0);
    chk("rst_frame_done", int'(bus.frame_done), 0);
    chk("rst_busy",       int'(bus.busy),       0);
`ifdef CAPTURE_ARM_EN
    chk("rst_armed",      int'(bus.armed),      0);
`endif
    clr_n = 1'b1;
    repeat (2) @(negedge dclk);

    // Partial frame, then reset mid-frame; the next frame must restart at Addr 0.
    wr0 = n_wr;
    drive_frame(2, H, 0, -1, -1, 1'b1);
    repeat (8) @(negedge dclk);
    chk("partial_writes", n_wr - wr0, 2 * H);
    chk("partial_busy",   int'(bus.busy), 1);
    clr_n = 1'b0;
    repeat (2) @(negedge dclk);
    chk("midrst_busy",  int'(bus.busy),  0);
    chk("midrst_write", int'(bus.Write), 0);
    exp_q.delete();
    clr_n = 1'b1;
    repeat (2) @(negedge dclk);

    for (int i = 0; i < 6; i++) begin
      wr0 = n_wr;
      dn0 = n_done;
      drive_frame(tab[i].lines, tab[i].px, tab[i].mode, tab[i].ab_row, tab[i].ab_col, 1'b1);
      repeat (12) @(negedge dclk);
      chk($sformatf("tab%0d_writes", i), n_wr - wr0, tab[i].exp_wr);
      chk($sformatf("tab%0d_done", i),   n_done - dn0, tab[i].exp_done);
      chk($sformatf("tab%0d_drained", i), exp_q.size(), 0);
      chk($sformatf("tab%0d_busy", i),   int'(bus.busy), 0);
    end

    for (int k = 0; k < 4; k++) begin
      drive_frame(V - 2 + int'($urandom_range(0, 5)), -1, 2, -1, -1, 1'b1);
      repeat (12) @(negedge dclk);
      chk($sformatf("rnd%0d_drained", k), exp_q.size(), 0);
      chk($sformatf("rnd%0d_done", k),    n_done, m_done);
    end

`ifdef CAPTURE_ARM_EN
    wr0 = n_wr;
    dn0 = n_done;
    drive_frame(V, H, 0, -1, -1, 1'b0);
    drive_frame(V, H, 0, -1, -1, 1'b0);
    repeat (12) @(negedge dclk);
    chk("unarmed_writes", n_wr - wr0, 0);
    chk("unarmed_done",   n_done - dn0, 0);
    wr0 = n_wr;
    drive_frame(V, H, 2, -1, -1, 1'b1);
    repeat (12) @(negedge dclk);
    chk("armed_writes",  n_wr - wr0, H * V);
    chk("armed_cleared", int'(bus.armed), 0);
    chk("armed_drained", exp_q.size(), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
